// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
// Command queue and single-issue stage that sits in front of the 4-bit alu.
// Operations {sel, b, a} are buffered in a small FIFO and issued one at a time
// on registered operand ports. After a fixed alu latency the 8-bit result is
// captured and offered on a valid/ready port tagged with its opcode.
// Completed results (result handshakes) are counted modulo 256.

module alu_op_sequencer #(
    parameter int DEPTH   = 4,   // FIFO entries, power of two, 2..16
    parameter int ALU_LAT = 1    // alu register stages, 0..7
) (
    input  logic                   clk,
    input  logic                   rst,          // asynchronous, active low
    // command push side
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [3:0]             cmd_a,
    input  logic [3:0]             cmd_b,
    input  logic [3:0]             cmd_sel,
    // drive to the alu and its result
    output logic [3:0]             alu_a,
    output logic [3:0]             alu_b,
    output logic [3:0]             alu_sel,
    input  logic [7:0]             alu_y,
    // result side
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [7:0]             res_y,
    output logic [3:0]             res_sel,
    // status
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic [7:0]             ops_done,
    output logic                   busy
);

    localparam int         PW       = $clog2(DEPTH);
    localparam int         CW       = PW + 1;
    localparam logic [2:0] LAT_INIT = 3'(ALU_LAT);

    // One queued operation; field order matches {cmd_sel, cmd_b, cmd_a}.
    typedef struct packed {
        logic [3:0] sel;
        logic [3:0] b;
        logic [3:0] a;
    } cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_HOLD
    } state_e;

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    cmd_t          mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    cmd_t          head;

    // ------------------------------------------------------------------
    // Issue / result state
    // ------------------------------------------------------------------
    state_e        state_q, state_d;
    logic [2:0]    wait_cnt_q, wait_cnt_d;
    cmd_t          issue_q, issue_d;      // operands on the alu; sel doubles as the result tag
    logic          res_valid_q, res_valid_d;
    logic [7:0]    res_y_q, res_y_d;
    logic [3:0]    res_sel_q, res_sel_d;
    logic [7:0]    ops_done_q, ops_done_d;

    assign fifo_full  = (count_q == CW'(DEPTH));
    assign fifo_empty = (count_q == '0);

    // Ready is withheld during reset and whenever the FIFO is full, even if a
    // pop happens in the same cycle; this keeps the ready path free of the
    // result handshake.
    assign cmd_ready  = rst & ~fifo_full;
    assign push       = cmd_valid & cmd_ready;
    assign head       = mem_q[rd_ptr_q];

    // FIFO storage: write the incoming command at the write pointer.
    // NOTE: sequential state is assigned with non-blocking (<=) so every flop
    // samples pre-edge values regardless of block ordering.
    // NOTE: the storage array is deliberately not reset; occupancy and
    // pointers alone decide what is valid, so stale entries are never read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {cmd_sel, cmd_b, cmd_a};
        end
    end

    // Pointer and occupancy next state; pointers wrap naturally at DEPTH.
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        count_d = count_q + CW'(push) - CW'(pop);
    end

    // FIFO pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Issue FSM next state: pop, wait out the alu latency, hold the result.
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        issue_d     = issue_q;
        res_valid_d = res_valid_q;
        res_y_d     = res_y_q;
        res_sel_d   = res_sel_q;
        ops_done_d  = ops_done_q;
        pop         = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // Only entries already stored are visible, so a command
                // pushed into an empty FIFO issues one cycle later.
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    issue_d    = head;
                    wait_cnt_d = LAT_INIT;
                    state_d    = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (wait_cnt_q != '0) begin
                    wait_cnt_d = wait_cnt_q - 3'd1;
                end else begin
                    res_y_d     = alu_y;
                    res_sel_d   = issue_q.sel;
                    res_valid_d = 1'b1;
                    state_d     = ST_HOLD;
                end
            end

            ST_HOLD: begin
                // res_valid is always set here, so res_ready alone completes
                // the handshake.
                if (res_ready) begin
                    ops_done_d  = ops_done_q + 8'd1;
                    res_valid_d = 1'b0;
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        issue_d    = head;
                        wait_cnt_d = LAT_INIT;
                        state_d    = ST_WAIT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Issue FSM, operand and result registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            wait_cnt_q  <= '0;
            issue_q     <= '0;
            res_valid_q <= 1'b0;
            res_y_q     <= '0;
            res_sel_q   <= '0;
            ops_done_q  <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            issue_q     <= issue_d;
            res_valid_q <= res_valid_d;
            res_y_q     <= res_y_d;
            res_sel_q   <= res_sel_d;
            ops_done_q  <= ops_done_d;
        end
    end

    assign alu_a      = issue_q.a;
    assign alu_b      = issue_q.b;
    assign alu_sel    = issue_q.sel;
    assign res_valid  = res_valid_q;
    assign res_y      = res_y_q;
    assign res_sel    = res_sel_q;
    assign fifo_count = count_q;
    assign ops_done   = ops_done_q;
    assign busy       = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer with DEPTH=4, ALU_LAT=1 and a
// registered y = a + b alu stub. A scoreboard queue receives the expected
// {y, sel} whenever a command is accepted and is compared on each result
// handshake. Inputs change 1ns after the rising edge; outputs are sampled on
// the falling edge.

module tb_alu_op_sequencer;

    localparam int DEPTH   = 4;
    localparam int ALU_LAT = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_a, cmd_b, cmd_sel;
    logic [3:0] alu_a, alu_b, alu_sel;
    logic [7:0] alu_y = 8'h00;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_y;
    logic [3:0] res_sel;
    logic [2:0] fifo_count;
    logic [7:0] ops_done;
    logic       busy;

    typedef struct {
        logic [7:0] y;
        logic [3:0] sel;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks    = 0;
    int   failures  = 0;
    int   n_results = 0;

    always #5 clk = ~clk;

    // Registered alu stub: y = a + b one cycle after the operands.
    always @(posedge clk) alu_y <= {4'b0, alu_a} + {4'b0, alu_b};

    alu_op_sequencer #(
        .DEPTH  (DEPTH),
        .ALU_LAT(ALU_LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_sel   (cmd_sel),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_sel   (alu_sel),
        .alu_y     (alu_y),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_y     (res_y),
        .res_sel   (res_sel),
        .fifo_count(fifo_count),
        .ops_done  (ops_done),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Scoreboard: record accepted commands, compare completed results.
    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
        end else begin
            if (res_valid && res_ready) begin
                n_results++;
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_result", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("sb_res_y", res_y, mon_e.y);
                    check("sb_res_sel", res_sel, mon_e.sel);
                end
            end
            if (cmd_valid && cmd_ready) begin
                exp_q.push_back('{y: {4'b0, cmd_a} + {4'b0, cmd_b}, sel: cmd_sel});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one command and return 1ns after the edge that accepted it.
    task automatic push_cmd(input logic [3:0] a, input logic [3:0] b, input logic [3:0] sel);
        bit ok;
        ok        = 1'b0;
        cmd_a     = a;
        cmd_b     = b;
        cmd_sel   = sel;
        cmd_valid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("push_timeout", 0, 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_alu_a"}, alu_a, 0);
        check({tag, "_alu_b"}, alu_b, 0);
        check({tag, "_alu_sel"}, alu_sel, 0);
        check({tag, "_res_valid"}, res_valid, 0);
        check({tag, "_res_y"}, res_y, 0);
        check({tag, "_res_sel"}, res_sel, 0);
        check({tag, "_ops_done"}, ops_done, 0);
        check({tag, "_fifo_count"}, fifo_count, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_cmd_ready"}, cmd_ready, 0);
    endtask

    // Wait (bounded) until nothing is queued, in flight or pending.
    task automatic wait_drain(input string tag);
        bit done;
        done = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (!busy && !res_valid) begin
                done = 1'b1;
                break;
            end
        end
        check(tag, done, 1);
    endtask

    task automatic wait_res_valid(input string tag);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (res_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check(tag, seen, 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int  lat;
        int  hs_n;
        int  last_cyc;
        int  base;
        bit  seen;
        bit  bad_ready, bad_rv, bad_y, bad_sel, bad_alu, bad_cnt;

        cmd_valid = 1'b0;
        cmd_a     = '0;
        cmd_b     = '0;
        cmd_sel   = '0;
        res_ready = 1'b0;
        rst       = 1'b0;

        // Reset state before any clock edge.
        #2;
        check_reset_outputs("por");
        tick();
        rst = 1'b1;

        // Single op: 7 + 14 = 0x15. Counting the cycle that starts at the
        // push edge as cycle 1, res_valid is seen in cycle ALU_LAT+3.
        res_ready = 1'b1;
        push_cmd(4'd7, 4'd14, 4'd3);
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (res_valid) begin
                lat = n;
                break;
            end
        end
        check("single_latency", lat, ALU_LAT + 3);
        check("single_res_y", res_y, 8'h15);
        check("single_res_sel", res_sel, 3);
        @(negedge clk);
        check("single_ops_done", ops_done, 1);
        check("single_res_valid_clear", res_valid, 0);
        check("single_busy_idle", busy, 0);

        // Reset while the operation is in WAIT.
        res_ready = 1'b0;
        tick();
        push_cmd(4'b0111, 4'b1110, 4'd2);
        tick();
        check("rst_pre_busy", busy, 1);
        rst = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        repeat (2) @(posedge clk);
        #1;
        rst  = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen |= res_valid;
        end
        check("rst_no_result", seen, 0);
        check("rst_fifo_count", fifo_count, 0);
        check("rst_busy", busy, 0);

        // Full FIFO with backpressure: cmd0 is issued and held, cmds 1..4
        // fill the FIFO, cmd5 must wait for the first result handshake.
        tick();
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_cmd(4'(i), 4'd1, 4'(i));
        cmd_a     = 4'd5;
        cmd_b     = 4'd1;
        cmd_sel   = 4'd5;
        cmd_valid = 1'b1;
        bad_ready = 1'b0;
        bad_rv    = 1'b0;
        bad_y     = 1'b0;
        bad_sel   = 1'b0;
        bad_alu   = 1'b0;
        bad_cnt   = 1'b0;
        repeat (10) begin
            @(negedge clk);
            bad_ready |= cmd_ready;
            bad_rv    |= !res_valid;
            bad_y     |= (res_y != 8'h01);
            bad_sel   |= (res_sel != 4'd0);
            bad_alu   |= (alu_a != 4'd0) || (alu_b != 4'd1) || (alu_sel != 4'd0);
            bad_cnt   |= (fifo_count != 3'd4);
        end
        check("full_cmd_ready_low", bad_ready, 0);
        check("bp_res_valid_held", bad_rv, 0);
        check("bp_res_y_stable", bad_y, 0);
        check("bp_res_sel_stable", bad_sel, 0);
        check("bp_alu_operands_held", bad_alu, 0);
        check("full_fifo_count", bad_cnt, 0);
        tick();
        res_ready = 1'b1;
        @(negedge clk);
        check("full_ready_low_during_pop", cmd_ready, 0);
        tick();
        res_ready = 1'b0;
        @(negedge clk);
        check("full_ops_done", ops_done, 1);
        check("full_next_issue_a", alu_a, 1);
        check("full_next_issue_sel", alu_sel, 1);
        check("full_fifo_after_pop", fifo_count, 3);
        check("full_cmd_ready_back", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        @(negedge clk);
        check("full_fifo_after_push5", fifo_count, 4);

        // Back-to-back: result pending with 4 queued, then res_ready held 1.
        wait_res_valid("b2b_first_result");
        tick();
        res_ready = 1'b1;
        hs_n      = 0;
        last_cyc  = 0;
        for (int c = 0; c < 40 && hs_n < 5; c++) begin
            @(negedge clk);
            if (res_valid && res_ready) begin
                check("b2b_fifo_count", fifo_count, 4 - hs_n);
                if (hs_n > 0) check("b2b_period", c - last_cyc, ALU_LAT + 2);
                last_cyc = c;
                hs_n++;
            end
        end
        check("b2b_handshakes", hs_n, 5);
        wait_drain("b2b_drain");
        check("b2b_ops_done", ops_done, 6);
        check("b2b_sb_empty", exp_q.size(), 0);

        // Counter wrap: 256 completed operations bring ops_done back to 0.
        tick();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        check("wrap_start_ops_done", ops_done, 0);
        res_ready = 1'b1;
        base      = n_results;
        for (int i = 0; i < 256; i++) begin
            push_cmd(4'($urandom_range(15)), 4'($urandom_range(15)), 4'($urandom_range(15)));
        end
        wait_drain("wrap_drain");
        check("wrap_results", n_results - base, 256);
        check("wrap_ops_done", ops_done, 0);

        // Simultaneous push and pop with two entries queued.
        tick();
        res_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push_cmd(4'($urandom_range(15)), 4'($urandom_range(15)), 4'(i + 8));
        end
        wait_res_valid("simul_result_pending");
        check("simul_count_before", fifo_count, 2);
        tick();
        cmd_a     = 4'd9;
        cmd_b     = 4'd9;
        cmd_sel   = 4'd12;
        cmd_valid = 1'b1;
        res_ready = 1'b1;
        @(negedge clk);
        check("simul_cmd_ready", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        @(negedge clk);
        check("simul_count_after", fifo_count, 2);
        wait_drain("simul_drain");
        check("simul_ops_done", ops_done, 4);
        check("final_sb_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
